// File: rtl/l1_pkg.sv
// Shared definitions for the L1 line-transfer logic.
//   l1_state_e          : line-sequencer state encoding
//   WORD_W / WORD_BYTES : data-store word geometry
//   DEF_LINE_WORDS_LOG2 : default log2(words per line)
package l1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_EVICT = 2'd2,
    ST_DRAIN = 2'd3
  } l1_state_e;

  localparam int WORD_BYTES          = 4;
  localparam int WORD_W              = 8 * WORD_BYTES;
  localparam int DEF_LINE_WORDS_LOG2 = 3;

endpackage

// File: rtl/l1_skid2.sv
// Two-entry FIFO used to absorb data-store read latency.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write din_i (ignored when full and not popping)
//   pop_i      : remove head (ignored when empty)
//   din_i      : data in
//   head_o     : oldest entry (meaningful when count_o != 0)
//   count_o    : number of entries held (0..2)
module l1_skid2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/l1_line_seq.sv
// Line-transfer sequencer for one port of the L1 data store.
// Serialises line fills (memory -> store) and evictions (store -> memory)
// into per-word store accesses; eviction wins over a simultaneous fill.
//   fill_start/fill_line   : fill request and line index
//   fill_data/valid/ready  : fill word stream in
//   fill_done              : pulse after the last fill word is written
//   evict_start/evict_line : eviction request and line index
//   evict_data/valid/ready : evicted word stream out
//   evict_done             : pulse after the last evicted word is taken
//   busy                   : active job or pending request
//   ds_addr/data/byte_enable/wr, ds_q : data-store port (1-cycle read latency)
module l1_line_seq
  import l1_pkg::*;
#(
  parameter int ADDR_WIDTH      = 10,
  parameter int LINE_WORDS_LOG2 = DEF_LINE_WORDS_LOG2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  fill_start,
  input  logic [ADDR_WIDTH-LINE_WORDS_LOG2-1:0] fill_line,
  input  logic [WORD_W-1:0]                     fill_data,
  input  logic                                  fill_valid,
  output logic                                  fill_ready,
  output logic                                  fill_done,
  input  logic                                  evict_start,
  input  logic [ADDR_WIDTH-LINE_WORDS_LOG2-1:0] evict_line,
  output logic [WORD_W-1:0]                     evict_data,
  output logic                                  evict_valid,
  input  logic                                  evict_ready,
  output logic                                  evict_done,
  output logic                                  busy,
  output logic [ADDR_WIDTH-1:0]                 ds_addr,
  output logic [WORD_W-1:0]                     ds_data,
  output logic [WORD_BYTES-1:0]                 ds_byte_enable,
  output logic                                  ds_wr,
  input  logic [WORD_W-1:0]                     ds_q
);

  localparam int LINE_W = ADDR_WIDTH - LINE_WORDS_LOG2;

  l1_state_e                  state_q, state_d;
  logic [LINE_WORDS_LOG2-1:0] beat_q, beat_d;
  logic [LINE_W-1:0]          line_q, line_d;
  logic                       fill_pend_q, fill_pend_d;
  logic [LINE_W-1:0]          fill_pline_q, fill_pline_d;
  logic                       evict_pend_q, evict_pend_d;
  logic [LINE_W-1:0]          evict_pline_q, evict_pline_d;
  logic                       inflight_q;
  logic                       fill_done_q, fill_done_d;
  logic                       evict_done_q, evict_done_d;

  logic                       grant_fill;
  logic                       grant_evict;
  logic                       fill_hs;
  logic                       last_beat;
  logic                       rd_issue;
  logic                       pop;
  logic [1:0]                 buf_count;
  logic [WORD_W-1:0]          buf_head;
  logic [2:0]                 occ;

  l1_skid2 #(.W(WORD_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .din_i   (ds_q),
    .head_o  (buf_head),
    .count_o (buf_count)
  );

  assign evict_valid = (buf_count != 2'd0);
  assign evict_data  = evict_valid ? buf_head : '0;
  assign pop         = evict_valid && evict_ready;
  assign fill_hs     = (state_q == ST_FILL) && fill_valid;
  assign last_beat   = (beat_q == '1);

  // Slots committed after this cycle's pop; a read is only issued when the
  // skid buffer is guaranteed room for its data one cycle later.
  assign occ      = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_issue = (state_q == ST_EVICT) && (occ < 3'd2);

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    line_d       = line_q;
    grant_fill   = 1'b0;
    grant_evict  = 1'b0;
    fill_done_d  = 1'b0;
    evict_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Dirty victim must leave before the refill of the same set.
        if (evict_pend_q || evict_start) begin
          state_d     = ST_EVICT;
          grant_evict = 1'b1;
          beat_d      = '0;
          line_d      = evict_pend_q ? evict_pline_q : evict_line;
        end else if (fill_pend_q || fill_start) begin
          state_d    = ST_FILL;
          grant_fill = 1'b1;
          beat_d     = '0;
          line_d     = fill_pend_q ? fill_pline_q : fill_line;
        end
      end
      ST_FILL: begin
        if (fill_hs) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            state_d     = ST_IDLE;
            fill_done_d = 1'b1;
          end
        end
      end
      ST_EVICT: begin
        if (rd_issue) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Finish in the cycle the final word is popped.
        if (!inflight_q &&
            ((buf_count == 2'd0) || ((buf_count == 2'd1) && pop))) begin
          state_d      = ST_IDLE;
          evict_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // One-deep request capture; a repeat start while pending is dropped.
  always_comb begin
    fill_pend_d   = fill_pend_q;
    fill_pline_d  = fill_pline_q;
    evict_pend_d  = evict_pend_q;
    evict_pline_d = evict_pline_q;
    if (grant_fill) begin
      fill_pend_d = 1'b0;
    end else if (fill_start && !fill_pend_q) begin
      fill_pend_d  = 1'b1;
      fill_pline_d = fill_line;
    end
    if (grant_evict) begin
      evict_pend_d = 1'b0;
    end else if (evict_start && !evict_pend_q) begin
      evict_pend_d  = 1'b1;
      evict_pline_d = evict_line;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      beat_q        <= '0;
      line_q        <= '0;
      fill_pend_q   <= 1'b0;
      fill_pline_q  <= '0;
      evict_pend_q  <= 1'b0;
      evict_pline_q <= '0;
      inflight_q    <= 1'b0;
      fill_done_q   <= 1'b0;
      evict_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      line_q        <= line_d;
      fill_pend_q   <= fill_pend_d;
      fill_pline_q  <= fill_pline_d;
      evict_pend_q  <= evict_pend_d;
      evict_pline_q <= evict_pline_d;
      inflight_q    <= rd_issue;
      fill_done_q   <= fill_done_d;
      evict_done_q  <= evict_done_d;
    end
  end

  always_comb begin
    ds_addr        = '0;
    ds_data        = '0;
    ds_byte_enable = '0;
    ds_wr          = 1'b0;
    if (state_q != ST_IDLE) begin
      ds_addr = {line_q, beat_q};
    end
    if (fill_hs) begin
      ds_wr          = 1'b1;
      ds_byte_enable = '1;
      ds_data        = fill_data;
    end
  end

  assign fill_ready = (state_q == ST_FILL);
  assign fill_done  = fill_done_q;
  assign evict_done = evict_done_q;
  assign busy       = (state_q != ST_IDLE) || fill_pend_q || evict_pend_q;

endmodule
